// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default adder geometry, adder FSM states, word type.
// Used by add_16_seq, its interface and its bench (ADD_SUB_MODE_EN does not change this file).
package alu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } add_state_t;

    typedef logic [15:0] word_t;

    // Slice index width; a single-slice adder still needs a 1-bit index.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_16_seq_if.sv
// Operand/result handshake bundle for add_16_seq: master is the ALU sequencer, slave is the adder.
// Optional macro ADD_SUB_MODE_EN adds the sub select line.
interface add_16_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADD_SUB_MODE_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

`ifdef ADD_SUB_MODE_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`endif

endinterface

// File: rtl/add_16_seq_nibble_adder.sv
// Combinational SLICE-bit ripple adder; c_msb is the carry into the top bit, used for signed overflow.
// Not affected by ADD_SUB_MODE_EN.
module nibble_adder #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/add_16_seq.sv
// Slice-serial WIDTH-bit adder: one SLICE-bit slice per clock through a shared nibble_adder.
// Define ADD_SUB_MODE_EN to add the sub input (a - b - cin, cout reported as borrow).
module add_16_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    add_16_seq_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    add_state_t       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_c;
    logic             sl_cmsb;
    logic             cout_rep;

`ifdef ADD_SUB_MODE_EN
    logic sub_q;

    // Subtraction is a + ~b + ~cin; the adder carry is the inverse of the borrow.
    assign b_in     = bus.sub ? ~bus.b : bus.b;
    assign cin_in   = bus.cin ^ bus.sub;
    assign cout_rep = sl_c ^ sub_q;
`else
    assign b_in     = bus.b;
    assign cin_in   = bus.cin;
    assign cout_rep = sl_c;
`endif

    assign sl_a = a_q[idx_q*SLICE +: SLICE];
    assign sl_b = b_q[idx_q*SLICE +: SLICE];

    nibble_adder #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry_q),
        .s     (sl_s),
        .cout  (sl_c),
        .c_msb (sl_cmsb)
    );

    always_comb begin
        res_d = res_q;
        res_d[idx_q*SLICE +: SLICE] = sl_s;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // Operand and partial-result storage carries no reset; the FSM decides when it is meaningful.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= b_in;
            res_q <= '0;
        end else if (state_q == CALC) begin
            res_q <= res_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
`ifdef ADD_SUB_MODE_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        carry_q <= cin_in;
                        idx_q   <= '0;
`ifdef ADD_SUB_MODE_EN
                        sub_q   <= bus.sub;
`endif
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    carry_q <= sl_c;
                    if (idx_q == IDX_LAST) begin
                        // The final slice is folded in directly so the result lands with out_valid.
                        sum_q       <= res_d;
                        cout_q      <= cout_rep;
                        ovf_q       <= sl_cmsb ^ sl_c;
                        zero_q      <= (res_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
